// File: rtl/parity_codec_pkg.sv
// parity_codec_pkg: shared parity target, coded-word bit layout and SRAM coded-word type
package parity_codec_pkg;
  localparam logic PARITY_EVEN = 1'b0;
  localparam int PB_BIT = 0;
  localparam int DATA_LSB = 1;
  typedef logic [32:0] parity_coded_t;
endpackage

// File: rtl/parity_codec_tree.sv
// parity_tree: combinational XOR reduction of a WIDTH-bit vector
module parity_tree #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  output logic             out
);
  assign out = ^in;
endmodule

// File: rtl/parity_codec.sv
// parity_codec: registered even-parity encoder/checker with sticky error flag and saturating error counter
module parity_codec
  import parity_codec_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enc_valid,
  input  logic [DATA_WIDTH-1:0]    enc_data,
  output logic                     enc_coded_valid,
  output logic [DATA_WIDTH:0]      enc_coded,
  input  logic                     chk_valid,
  input  logic [DATA_WIDTH:0]      chk_coded,
  output logic                     chk_data_valid,
  output logic [DATA_WIDTH-1:0]    chk_data,
  output logic                     chk_error,
  input  logic                     err_clear,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);
  logic enc_par, chk_par, bad;
  parity_tree #(.WIDTH(DATA_WIDTH))   u_enc_tree (.in(enc_data),  .out(enc_par));
  parity_tree #(.WIDTH(DATA_WIDTH+1)) u_chk_tree (.in(chk_coded), .out(chk_par));
  assign bad = chk_valid & (chk_par != PARITY_EVEN);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      enc_coded_valid <= 1'b0;
      enc_coded       <= '0;
    end else begin
      enc_coded_valid <= enc_valid;
      if (enc_valid) enc_coded <= {enc_data, enc_par};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      chk_data_valid <= 1'b0;
      chk_data       <= '0;
      chk_error      <= 1'b0;
    end else begin
      chk_data_valid <= chk_valid;
      chk_error      <= bad;
      if (chk_valid) chk_data <= chk_coded[DATA_WIDTH:DATA_LSB];
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (bad) begin
      err_sticky <= 1'b1;
      err_count  <= (err_count == '1) ? err_count : err_count + 1'b1;
    end
endmodule

// File: tb/tb_parity_codec.sv
// tb_parity_codec: directed and randomised round-trip checks of parity_codec against hand-computed values
module tb_parity_codec;
  logic        clk = 1'b0;
  logic        reset;
  logic        enc_valid, chk_valid, err_clear;
  logic [31:0] enc_data;
  logic [32:0] chk_coded;
  logic        enc_coded_valid, chk_data_valid, chk_error, err_sticky;
  logic [32:0] enc_coded;
  logic [31:0] chk_data;
  logic [7:0]  err_count;
  int          n_checks = 0;
  int          n_fail = 0;
  parity_codec #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .enc_valid(enc_valid), .enc_data(enc_data),
    .enc_coded_valid(enc_coded_valid), .enc_coded(enc_coded),
    .chk_valid(chk_valid), .chk_coded(chk_coded),
    .chk_data_valid(chk_data_valid), .chk_data(chk_data), .chk_error(chk_error),
    .err_clear(err_clear), .err_sticky(err_sticky), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    enc_valid = 1'b0;
    chk_valid = 1'b0;
    err_clear = 1'b0;
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, " enc_coded_valid"}, 64'(enc_coded_valid), 64'd0);
    check({tag, " enc_coded"}, 64'(enc_coded), 64'd0);
    check({tag, " chk_data_valid"}, 64'(chk_data_valid), 64'd0);
    check({tag, " chk_data"}, 64'(chk_data), 64'd0);
    check({tag, " chk_error"}, 64'(chk_error), 64'd0);
    check({tag, " err_sticky"}, 64'(err_sticky), 64'd0);
    check({tag, " err_count"}, 64'(err_count), 64'd0);
  endtask
  initial begin
    logic [31:0] w;
    logic [32:0] coded, mask;
    int          nf, b1, b2;
    int          exp_cnt;
    reset = 1'b0;
    enc_valid = 1'b0;
    chk_valid = 1'b0;
    err_clear = 1'b0;
    enc_data = '0;
    chk_coded = '0;
    #12;
    check_all_zero("reset");
    reset = 1'b1;
    enc_valid = 1'b1; enc_data = 32'h0000_0000; step;
    check("enc0 valid", 64'(enc_coded_valid), 64'd1);
    check("enc0 coded", 64'(enc_coded), 64'h0_0000_0000);
    enc_valid = 1'b1; enc_data = 32'h0000_0001; step;
    check("enc1 coded", 64'(enc_coded), 64'h0_0000_0003);
    enc_valid = 1'b1; enc_data = 32'hFFFF_FFFF; step;
    check("encF coded", 64'(enc_coded), 64'h1_FFFF_FFFE);
    check("idle enc valid", 64'(enc_coded_valid), 64'd1);
    step;
    check("enc valid drop", 64'(enc_coded_valid), 64'd0);
    check("enc hold", 64'(enc_coded), 64'h1_FFFF_FFFE);
    chk_valid = 1'b1; chk_coded = 33'h0_0000_0003; step;
    check("chk good data", 64'(chk_data), 64'h1);
    check("chk good err", 64'(chk_error), 64'd0);
    check("chk good valid", 64'(chk_data_valid), 64'd1);
    chk_valid = 1'b1; chk_coded = 33'h0_0000_0002; step;
    check("chk bad data", 64'(chk_data), 64'h1);
    check("chk bad err", 64'(chk_error), 64'd1);
    check("chk bad sticky", 64'(err_sticky), 64'd1);
    check("chk bad count", 64'(err_count), 64'd1);
    exp_cnt = 1;
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      nf = $urandom_range(0, 2);
      coded = {w, ^w};
      mask = '0;
      b1 = $urandom_range(0, 32);
      b2 = (b1 + 1 + $urandom_range(0, 31)) % 33;
      if (nf >= 1) mask[b1] = 1'b1;
      if (nf == 2) mask[b2] = 1'b1;
      enc_valid = 1'b1; enc_data = w;
      chk_valid = 1'b1; chk_coded = coded ^ mask;
      step;
      if (nf == 1 && exp_cnt < 255) exp_cnt++;
      check("rt enc", 64'(enc_coded), 64'(coded));
      check("rt data", 64'(chk_data), 64'((coded ^ mask) >> 1));
      check("rt err", 64'(chk_error), 64'(nf == 1));
      if (nf == 1 && b1 == 0) check("rt payload", 64'(chk_data), 64'(w));
    end
    check("rt count", 64'(err_count), 64'(exp_cnt));
    err_clear = 1'b1; step;
    check("clr count", 64'(err_count), 64'd0);
    check("clr sticky", 64'(err_sticky), 64'd0);
    for (int i = 0; i < 300; i++) begin
      chk_valid = 1'b1; chk_coded = 33'h0_0000_0001; step;
      if (i == 253) check("sat count 254", 64'(err_count), 64'hFE);
    end
    check("sat count", 64'(err_count), 64'hFF);
    check("sat sticky", 64'(err_sticky), 64'd1);
    err_clear = 1'b1; chk_valid = 1'b1; chk_coded = 33'h0_0000_0001; step;
    check("clr pri count", 64'(err_count), 64'd0);
    check("clr pri sticky", 64'(err_sticky), 64'd0);
    check("clr pri err", 64'(chk_error), 64'd1);
    chk_valid = 1'b1; chk_coded = {32'h1234_5678, 1'b1}; step;
    check("good 5 err", 64'(chk_error), 64'd0);
    chk_valid = 1'b0; chk_coded = 33'h0_0000_0001; step;
    check("noval err", 64'(chk_error), 64'd0);
    check("noval valid", 64'(chk_data_valid), 64'd0);
    check("noval hold", 64'(chk_data), 64'h1234_5678);
    check("noval count", 64'(err_count), 64'd0);
    enc_valid = 1'b1; enc_data = 32'hA5A5_0001;
    chk_valid = 1'b1; chk_coded = 33'h1_0000_0001; step;
    check("sim enc", 64'(enc_coded), 64'h1_4B4A_0003);
    check("sim data", 64'(chk_data), 64'h8000_0000);
    check("sim err", 64'(chk_error), 64'd0);
    enc_valid = 1'b1; enc_data = 32'hFFFF_FFFF;
    chk_valid = 1'b1; chk_coded = 33'h0_0000_0002; step;
    check("pre rst err", 64'(chk_error), 64'd1);
    check("pre rst count", 64'(err_count), 64'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("async rst");
    step;
    check_all_zero("held rst");
    reset = 1'b1;
    enc_valid = 1'b1; enc_data = 32'h0000_0001;
    chk_valid = 1'b1; chk_coded = 33'h0_0000_0003; step;
    check("post rst enc valid", 64'(enc_coded_valid), 64'd1);
    check("post rst enc", 64'(enc_coded), 64'h3);
    check("post rst chk valid", 64'(chk_data_valid), 64'd1);
    check("post rst data", 64'(chk_data), 64'h1);
    check("post rst err", 64'(chk_error), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
